branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/bpu_pkg.sv | 24 ++
 rtl/bpu_pht.sv | 33 +++
 rtl/branch_predict_unit.sv | 99 +++++++++
 tb/tb_branch_predict_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared definitions for the branch predictor: saturating counter update
// and the weakly-not-taken reset value, both parameterised on counter width.
package bpu_pkg;

   // Widest counter the helpers below support.
   localparam int unsigned CTR_MAX_W = 16;

   function automatic logic [CTR_MAX_W-1:0] wnt_value(input int unsigned w);
      if (w <= 1) return '0;
      return CTR_MAX_W'((1 << (w - 1)) - 1);
   endfunction

   function automatic logic [CTR_MAX_W-1:0] ctr_update(
      input logic [CTR_MAX_W-1:0] ctr,
      input logic                 taken,
      input int unsigned          w
   );
      logic [CTR_MAX_W-1:0] max_v;
      max_v = CTR_MAX_W'((1 << w) - 1);
      if (taken) return (ctr >= max_v) ? max_v : ctr + CTR_MAX_W'(1);
      return (ctr == '0) ? '0 : ctr - CTR_MAX_W'(1);
   endfunction

endpackage

// File: rtl/bpu_pht.sv
// Pattern history table: one combinational read port, one update port that
// applies the saturating counter step. A same-cycle read sees the old value.
module bpu_pht
   import bpu_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int CTR_W   = 2,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [CTR_W-1:0] rd_ctr,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_taken
);

   localparam logic [CTR_W-1:0] WNT = CTR_W'(wnt_value(CTR_W));

   logic [CTR_W-1:0] pht_q [ENTRIES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) pht_q[i] <= WNT;
      end else if (wr_en) begin
         pht_q[wr_idx] <= CTR_W'(ctr_update(CTR_MAX_W'(pht_q[wr_idx]), wr_taken, CTR_W));
      end
   end

   assign rd_ctr = pht_q[rd_idx];

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: registered lookup path, registered resolution
// path producing the corrected PC and flush/success pulses, plus event counters.
module branch_predict_unit
   import bpu_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int ENTRIES = 16,
   parameter int CTR_W   = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pred_valid,
   input  logic [XLEN-1:0] pred_pc,
   input  logic [XLEN-1:0] pred_offset,
   output logic            pred_out_valid,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            res_valid,
   input  logic [XLEN-1:0] res_pc,
   input  logic [XLEN-1:0] res_offset,
   input  logic            res_taken,
   input  logic            res_pred_taken,
   output logic [XLEN-1:0] next_pc,
   output logic            flush,
   output logic            prediction_success,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
);

   localparam int IDX_W = $clog2(ENTRIES);

   // Both request ports are valid-only (no backpressure): a request is
   // consumed on every rising edge where its valid is high, and the matching
   // result is presented for exactly the following cycle.

   logic [CTR_W-1:0] rd_ctr;
   logic             lookup_taken;
   logic [XLEN-1:0]  lookup_target;
   logic [XLEN-1:0]  resolved_pc;
   logic             mispredict;

   bpu_pht #(
      .ENTRIES (ENTRIES),
      .CTR_W   (CTR_W)
   ) u_pht (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (pred_pc[IDX_W+1:2]),
      .rd_ctr   (rd_ctr),
      .wr_en    (res_valid),
      .wr_idx   (res_pc[IDX_W+1:2]),
      .wr_taken (res_taken)
   );

   always_comb begin
      lookup_taken  = rd_ctr[CTR_W-1];
      lookup_target = lookup_taken ? (pred_pc + pred_offset) : (pred_pc + XLEN'(4));
      resolved_pc   = res_taken ? (res_pc + res_offset) : (res_pc + XLEN'(4));
      mispredict    = (res_taken != res_pred_taken);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pred_out_valid <= 1'b0;
         pred_taken     <= 1'b0;
         pred_target    <= '0;
      end else begin
         pred_out_valid <= pred_valid;
         if (pred_valid) begin
            pred_taken  <= lookup_taken;
            pred_target <= lookup_target;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         next_pc            <= '0;
         flush              <= 1'b0;
         prediction_success <= 1'b0;
      end else begin
         flush              <= res_valid & mispredict;
         prediction_success <= res_valid & ~mispredict;
         if (res_valid) next_pc <= resolved_pc;
      end
   end

   // Counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else if (res_valid) begin
         if (stat_branches != '1) stat_branches <= stat_branches + 32'd1;
         if (mispredict && (stat_mispredicts != '1)) stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomised and directed bench for branch_predict_unit, checked against a
// behavioural predictor model through expected-result queues.
module tb_branch_predict_unit;

   localparam int XLEN    = 64;
   localparam int ENTRIES = 16;
   localparam int CTR_W   = 2;
   localparam int CMAX    = 3;   // 2^CTR_W - 1
   localparam int WNT     = 1;   // weakly not taken
   localparam int TAKE_AT = 2;   // counter value from which we predict taken

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            pred_valid = 1'b0;
   logic [XLEN-1:0] pred_pc = '0;
   logic [XLEN-1:0] pred_offset = '0;
   logic            pred_out_valid;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;
   logic            res_valid = 1'b0;
   logic [XLEN-1:0] res_pc = '0;
   logic [XLEN-1:0] res_offset = '0;
   logic            res_taken = 1'b0;
   logic            res_pred_taken = 1'b0;
   logic [XLEN-1:0] next_pc;
   logic            flush;
   logic            prediction_success;
   logic [31:0]     stat_branches;
   logic [31:0]     stat_mispredicts;

   branch_predict_unit #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_W(CTR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_offset(pred_offset),
      .pred_out_valid(pred_out_valid), .pred_taken(pred_taken), .pred_target(pred_target),
      .res_valid(res_valid), .res_pc(res_pc), .res_offset(res_offset),
      .res_taken(res_taken), .res_pred_taken(res_pred_taken),
      .next_pc(next_pc), .flush(flush), .prediction_success(prediction_success),
      .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
   );

   // ---------------- clock / cycle count ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard state ----------------
   typedef struct {
      int              due;
      logic            taken;
      logic [XLEN-1:0] target;
   } pred_exp_t;

   typedef struct {
      int              due;
      logic [XLEN-1:0] npc;
      logic            flush;
      logic            success;
      logic [31:0]     br;
      logic [31:0]     mis;
   } res_exp_t;

   pred_exp_t pred_q[$];
   res_exp_t  res_q[$];

   int total = 0;
   int bad   = 0;

   // reference model
   int          m_ctr[ENTRIES];
   logic [31:0] m_br, m_mis;

   // last values the DUT should be holding between results
   logic            last_pt;
   logic [XLEN-1:0] last_tg;
   logic [XLEN-1:0] last_npc;
   logic [31:0]     last_br, last_mis;

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int idx_of(input logic [XLEN-1:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) m_ctr[i] = WNT;
      m_br = 0; m_mis = 0;
      last_pt = 1'b0; last_tg = '0; last_npc = '0; last_br = '0; last_mis = '0;
      pred_q.delete();
      res_q.delete();
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (pred_out_valid) begin
            if (pred_q.size() == 0) begin
               chk("pred_unexpected", 1, 0);
            end else begin
               pred_exp_t p;
               p = pred_q.pop_front();
               chk("pred_latency", XLEN'(cyc), XLEN'(p.due));
               chk("pred_taken", XLEN'(pred_taken), XLEN'(p.taken));
               chk("pred_target", pred_target, p.target);
               last_pt = p.taken; last_tg = p.target;
            end
         end else begin
            if (pred_q.size() > 0 && pred_q[0].due <= cyc) begin
               chk("pred_missing", 0, 1);
               void'(pred_q.pop_front());
            end
            chk("pred_taken_hold", XLEN'(pred_taken), XLEN'(last_pt));
            chk("pred_target_hold", pred_target, last_tg);
         end

         if (flush || prediction_success) begin
            if (res_q.size() == 0) begin
               chk("res_unexpected", 1, 0);
            end else begin
               res_exp_t r;
               r = res_q.pop_front();
               chk("res_latency", XLEN'(cyc), XLEN'(r.due));
               chk("next_pc", next_pc, r.npc);
               chk("flush", XLEN'(flush), XLEN'(r.flush));
               chk("prediction_success", XLEN'(prediction_success), XLEN'(r.success));
               chk("stat_branches", XLEN'(stat_branches), XLEN'(r.br));
               chk("stat_mispredicts", XLEN'(stat_mispredicts), XLEN'(r.mis));
               last_npc = r.npc; last_br = r.br; last_mis = r.mis;
            end
         end else begin
            if (res_q.size() > 0 && res_q[0].due <= cyc) begin
               chk("res_missing", 0, 1);
               void'(res_q.pop_front());
            end
            chk("next_pc_hold", next_pc, last_npc);
            chk("stat_branches_hold", XLEN'(stat_branches), XLEN'(last_br));
            chk("stat_mispredicts_hold", XLEN'(stat_mispredicts), XLEN'(last_mis));
         end
      end
   end

   // ---------------- driver ----------------
   // Called just after a rising edge; presents one cycle of requests and
   // returns just after the edge that consumes them.
   task automatic step(input logic pv, input logic [XLEN-1:0] ppc, input logic [XLEN-1:0] poff,
                       input logic rv, input logic [XLEN-1:0] rpc, input logic [XLEN-1:0] roff,
                       input logic rt, input logic rpt);
      if (pv) begin
         pred_exp_t p;
         p.due    = cyc + 1;
         p.taken  = (m_ctr[idx_of(ppc)] >= TAKE_AT);
         p.target = p.taken ? ppc + poff : ppc + 64'd4;
         pred_q.push_back(p);
      end
      if (rv) begin
         res_exp_t r;
         int       i;
         i = idx_of(rpc);
         if (m_br != 32'hFFFF_FFFF) m_br++;
         if (rt != rpt && m_mis != 32'hFFFF_FFFF) m_mis++;
         r.due     = cyc + 1;
         r.npc     = rt ? rpc + roff : rpc + 64'd4;
         r.flush   = (rt != rpt);
         r.success = (rt == rpt);
         r.br      = m_br;
         r.mis     = m_mis;
         res_q.push_back(r);
         if (rt) m_ctr[i] = (m_ctr[i] == CMAX) ? CMAX : m_ctr[i] + 1;
         else    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end
      pred_valid = pv; pred_pc = ppc; pred_offset = poff;
      res_valid = rv; res_pc = rpc; res_offset = roff; res_taken = rt; res_pred_taken = rpt;
      @(posedge clk); #1;
      pred_valid = 1'b0; res_valid = 1'b0;
   endtask

   task automatic predict(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] off);
      step(1'b1, pc, off, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic resolve(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] off, input logic t, input logic pt);
      step(1'b0, '0, '0, 1'b1, pc, off, t, pt);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      pred_valid = 1'b0; res_valid = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [XLEN-1:0] rpc, roff, ppc, poff;
      logic [11:0]     r12;

      reset_dut();
      chk("rst_pred_out_valid", XLEN'(pred_out_valid), 0);
      chk("rst_flush", XLEN'(flush), 0);
      chk("rst_success", XLEN'(prediction_success), 0);
      chk("rst_next_pc", next_pc, 0);
      chk("rst_stat_branches", XLEN'(stat_branches), 0);

      // fresh table predicts not taken, fall-through target
      predict(64'h100, 64'h40);
      chk("reset_pred_taken", XLEN'(pred_taken), 0);
      chk("reset_pred_target", pred_target, 64'h104);

      // read-before-write on index 0 (counter 1 -> 2)
      step(1'b1, 64'h40, 64'h10, 1'b1, 64'h40, 64'h10, 1'b1, 1'b0);
      chk("collide_old_value", XLEN'(pred_taken), 0);
      predict(64'h40, 64'h10);
      chk("collide_new_value", XLEN'(pred_taken), 1);
      chk("collide_target", pred_target, 64'h50);

      // training on 0x100
      resolve(64'h100, 64'h40, 1'b1, 1'b0);
      resolve(64'h100, 64'h40, 1'b1, 1'b1);
      predict(64'h100, 64'h40);
      chk("train_taken", XLEN'(pred_taken), 1);
      chk("train_target", pred_target, 64'h140);

      // mispredict with negative offset
      resolve(64'h200, -64'sd8, 1'b1, 1'b0);
      chk("mis_next_pc", next_pc, 64'h1F8);
      chk("mis_flush", XLEN'(flush), 1);
      chk("mis_count", XLEN'(stat_mispredicts), XLEN'(m_mis));
      idle(1);
      chk("mis_flush_one_cycle", XLEN'(flush), 0);

      // saturation on index 2
      for (int k = 0; k < 5; k++) resolve(64'h308, 64'h20, 1'b1, 1'b1);
      resolve(64'h308, 64'h20, 1'b0, 1'b1);
      predict(64'h308, 64'h20);
      chk("sat_still_taken", XLEN'(pred_taken), 1);
      chk("sat_target", pred_target, 64'h328);

      // PC wrap on fall-through
      resolve(64'hFFFF_FFFF_FFFF_FFFC, 64'h100, 1'b0, 1'b0);
      chk("wrap_next_pc", next_pc, 64'h0);
      chk("wrap_success", XLEN'(prediction_success), 1);

      // random traffic
      for (int k = 0; k < 400; k++) begin
         r12  = 12'($urandom);
         roff = {{52{r12[11]}}, r12[11:2], 2'b00};
         r12  = 12'($urandom);
         poff = {{52{r12[11]}}, r12[11:2], 2'b00};
         rpc  = {$urandom(), $urandom()} & ~64'h3;
         ppc  = ($urandom_range(0, 3) == 0) ? rpc : ({$urandom(), $urandom()} & ~64'h3);
         step(1'($urandom_range(0, 1)), ppc, poff,
              1'($urandom_range(0, 1)), rpc, roff,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 9) == 0) idle(1);
      end
      idle(2);

      // reset while a resolution result is on the outputs
      resolve(64'h400, 64'h80, 1'b1, 1'b0);
      chk("pre_reset_flush", XLEN'(flush), 1);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_rst_flush", XLEN'(flush), 0);
      chk("async_rst_next_pc", next_pc, 0);
      chk("async_rst_branches", XLEN'(stat_branches), 0);
      chk("async_rst_mispredicts", XLEN'(stat_mispredicts), 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // update presented while reset is held must not land
      for (int k = 0; k < 2; k++) resolve(64'h308, 64'h20, 1'b1, 1'b1);
      @(negedge clk);
      res_valid = 1'b1; res_pc = 64'h308; res_taken = 1'b1; res_pred_taken = 1'b1;
      rst_n = 1'b0;
      model_reset();
      @(posedge clk); #1;
      res_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      predict(64'h308, 64'h20);
      chk("reset_discard_taken", XLEN'(pred_taken), 0);
      chk("reset_discard_target", pred_target, 64'h30C);

      idle(3);
      chk("pred_queue_drained", XLEN'(pred_q.size()), 0);
      chk("res_queue_drained", XLEN'(res_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
